mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
Final pipeline stage, directly downstream of the execute/calc stage. Consumes the registered ALU result and load/store control from execute. Waits on the data-memory read response for loads, then aligns and sign/zero-extends the load data. Drives the register-file write port plus a forwarding tap back to decode/execute, and stalls upstream while a load response is outstanding.

Parameters:
XLEN, 32, datapath width (fixed at 32 for this revision)
RA_W, 5, register-address width
MAX_WAIT, 15, cycles to wait for a read response before raising timeout

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous active-low reset
ex_valid  input  1  execute presents a valid instruction this cycle
ex_rd  input  RA_W  destination register
ex_wb_en  input  1  instruction writes a register
ex_mem_read  input  1  instruction is a load
ex_funct3  input  3  load size/sign (0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU)
ex_alu_result  input  XLEN  ALU result; for loads, the byte address
mem_rsp_valid  input  1  read-data strobe from data memory
mem_rsp_data  input  XLEN  word-aligned read data
stall_out  output  1  upstream must hold its outputs
rf_we  output  1  register-file write enable
rf_waddr  output  RA_W  register-file write address
rf_wdata  output  XLEN  register-file write data
fwd_valid  output  1  equals rf_we; forwarding tap
fwd_rd  output  RA_W  equals rf_waddr
fwd_data  output  XLEN  equals rf_wdata
err_misalign  output  1  one-cycle pulse on a misaligned load
err_timeout  output  1  one-cycle pulse when a response does not arrive in time

Behaviour:
- Reset (reset=0, asynchronous): state IDLE. All outputs are 0, all capture registers are 0, and the wait counter is 0.
- FSM states:
  - IDLE: sample ex_* each cycle.
    - ex_valid & !ex_mem_read & ex_wb_en & ex_rd!=0 -> state WB. rf_we=1 next cycle with ex_alu_result (latency 1).
    - ex_valid & ex_mem_read & aligned -> capture rd, funct3, addr[1:0] -> state WAIT.
    - ex_valid & ex_mem_read & misaligned -> err_misalign=1 next cycle; no write; stay IDLE. Misaligned means LH/LHU with addr[0]=1, or LW with addr[1:0]!=0.
    - Any other case: no action.
  - WAIT: stall_out=1, driven combinationally from state. ex_* inputs are ignored.
    - mem_rsp_valid -> state WB. Data is extracted from byte lane addr[1:0] (LB/LBU) or half lane addr[1] (LH/LHU), then sign- or zero-extended to XLEN.
    - If the wait counter reaches MAX_WAIT with no response -> err_timeout=1 for one cycle, no write, state IDLE.
  - WB: rf_we=1 for exactly one cycle -> state IDLE.
    - The stage also samples ex_* in this cycle, as IDLE does, so back-to-back ALU ops retire one per cycle.
- Load latency: a response in cycle M gives rf_we=1 in cycle M+1.
- mem_rsp_valid outside WAIT is ignored.
- A response in the same cycle the load is captured is not accepted. Memory latency is at least 1 cycle.
- rd=0:
  - Non-loads produce no write.
  - Loads to rd=0 still wait for the response, so the bus transaction completes, but rf_we stays 0.
- rf_waddr and rf_wdata hold their last values when rf_we=0.
- The fwd_* outputs are wire copies of the rf_* outputs.
- Wait counter: saturating, width clog2(MAX_WAIT+1). Cleared on entry to WAIT.
- Reset asserted in WAIT: abort to IDLE with no write. A late response after reset is ignored.
- Unknown funct3 on a load (3, 6, 7): treated as LW, including for the alignment check.

Optional Feature:
MEM_WB_PERF_EN
- Defined:
  - Adds output perf_retired (32-bit): increments on every rf_we=1 cycle.
  - Adds output perf_load_stall (32-bit): increments on every WAIT cycle.
  - Both counters wrap at 2^32 and reset to 0.
- Undefined: neither port nor the counters exist. Behaviour is otherwise identical.

Test Plan:
- ALU writeback: reset release; ex_valid=1, ex_wb_en=1, ex_rd=5, ex_alu_result=0x1234 for one cycle -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234, stall_out=0 throughout.
- LB sign extension: load funct3=0 at addr 0x103; response 2 cycles later with data 0x80AABBCC -> stall_out=1 for 2 cycles, then rf_wdata=0xFFFFFF80 one cycle after the response. Repeat with funct3=4 -> 0x00000080.
- Misaligned LW at addr 0x102 -> err_misalign pulses for 1 cycle; rf_we stays 0; stall_out stays 0.
- Timeout: load issued with no response for MAX_WAIT=15 cycles -> err_timeout pulses once; FSM returns to IDLE; a response arriving afterwards causes no write.
- Back-to-back ALU ops on rd=1,2,3 in consecutive cycles -> three consecutive rf_we cycles carrying the matching data; rd=0 in between -> no write in its slot.
- Reset mid-WAIT: drive reset=0 two cycles after a load is captured -> all outputs go to 0 immediately; after reset release a response is ignored. With MEM_WB_PERF_EN, perf_load_stall reads 0 after reset.

Source files
------------

// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
//
// This is the final pipeline stage, placed after the execute stage. It takes
// the registered ALU result and the load/store control from execute.
//   - ALU ops write the register file one cycle after they are presented.
//   - Aligned loads park the stage in WAIT until the data-memory read response
//     arrives. The stage then selects the addressed byte or halfword, sign- or
//     zero-extends it, and writes it one cycle after the response.
//   - Misaligned loads and responses that do not arrive in time each produce a
//     one-cycle error pulse and no write.
//
// Optional feature (macro MEM_WB_PERF_EN):
//   When defined, the stage gains two free-running 32-bit counters.
//   perf_retired counts rf_we cycles. perf_load_stall counts WAIT cycles.
//
// Ports:
//   clk, reset                 clock (rising edge), async active-low reset
//   ex_valid/ex_rd/ex_wb_en    instruction from execute
//   ex_mem_read/ex_funct3      load flag and load size/sign
//   ex_alu_result              ALU result / load byte address
//   mem_rsp_valid/_data        read response from data memory
//   stall_out                  upstream hold (combinational from state)
//   rf_we/rf_waddr/rf_wdata    register-file write port (registered)
//   fwd_valid/fwd_rd/fwd_data  forwarding tap, copies of rf_*
//   err_misalign/err_timeout   one-cycle error pulses
//   perf_retired/perf_load_stall  (MEM_WB_PERF_EN only)
// -----------------------------------------------------------------------------
module mem_wb_stage #(
    parameter int XLEN     = 32,
    parameter int RA_W     = 5,
    parameter int MAX_WAIT = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ex_valid,
    input  logic [RA_W-1:0] ex_rd,
    input  logic            ex_wb_en,
    input  logic            ex_mem_read,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_alu_result,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    output logic            stall_out,
    output logic            rf_we,
    output logic [RA_W-1:0] rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            fwd_valid,
    output logic [RA_W-1:0] fwd_rd,
    output logic [XLEN-1:0] fwd_data,
    output logic            err_misalign,
    output logic            err_timeout
`ifdef MEM_WB_PERF_EN
    ,
    output logic [31:0]     perf_retired,
    output logic [31:0]     perf_load_stall
`endif
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_next_s;

    logic [RA_W-1:0]   cap_rd_r;
    logic [2:0]        cap_funct3_r;
    logic [1:0]        cap_off_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_inc_s;

    logic              rf_we_r;
    logic [RA_W-1:0]   rf_waddr_r;
    logic [XLEN-1:0]   rf_wdata_r;
    logic              err_misalign_r;
    logic              err_timeout_r;

    logic              accept_alu_s;
    logic              accept_load_s;
    logic              misalign_s;
    logic              rsp_take_s;
    logic              timeout_s;
    logic              stall_s;
    logic              wr_next_s;
    logic [RA_W-1:0]   waddr_next_s;
    logic [XLEN-1:0]   wdata_next_s;

    // Funct3 values 3, 6 and 7 are not defined. They are treated as LW, so
    // they need word alignment.
    function automatic logic load_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic mis;
        case (f3)
            3'd0, 3'd4: mis = 1'b0;
            3'd1, 3'd5: mis = off[0];
            default:    mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

    // Selects the addressed byte or halfword lane from the word-aligned
    // response and extends it to XLEN. Undefined funct3 values pass the whole
    // word through.
    function automatic logic [XLEN-1:0] load_extract(input logic [2:0]      f3,
                                                     input logic [1:0]      off,
                                                     input logic [XLEN-1:0] w);
        logic [7:0]      b;
        logic [15:0]     h;
        logic [XLEN-1:0] r;
        b = w[{off, 3'b000} +: 8];
        h = w[{off[1], 4'b0000} +: 16];
        case (f3)
            3'd0:    r = {{(XLEN-8){b[7]}}, b};
            3'd4:    r = {{(XLEN-8){1'b0}}, b};
            3'd1:    r = {{(XLEN-16){h[15]}}, h};
            3'd5:    r = {{(XLEN-16){1'b0}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    assign cnt_inc_s = (cnt_r == MAX_CNT) ? cnt_r : (cnt_r + {{(CNT_W-1){1'b0}}, 1'b1});

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic. The WB state samples ex_* just as IDLE does, so
    // back-to-back instructions retire one per cycle.
    always_comb begin
        state_next_s  = ST_IDLE;
        accept_alu_s  = 1'b0;
        accept_load_s = 1'b0;
        misalign_s    = 1'b0;
        rsp_take_s    = 1'b0;
        timeout_s     = 1'b0;
        case (state_r)
            ST_IDLE, ST_WB: begin
                if (ex_valid && ex_mem_read) begin
                    if (load_misaligned(ex_funct3, ex_alu_result[1:0])) begin
                        misalign_s   = 1'b1;
                        state_next_s = ST_IDLE;
                    end else begin
                        accept_load_s = 1'b1;
                        state_next_s  = ST_WAIT;
                    end
                end else if (ex_valid && ex_wb_en && (ex_rd != {RA_W{1'b0}})) begin
                    accept_alu_s = 1'b1;
                    state_next_s = ST_WB;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (mem_rsp_valid) begin
                    // A load to x0 still completes its bus transaction. It
                    // then returns straight to IDLE without writing.
                    rsp_take_s = 1'b1;
                    if (cap_rd_r != {RA_W{1'b0}}) begin
                        state_next_s = ST_WB;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else if (cnt_inc_s == MAX_CNT) begin
                    // This is the MAX_WAIT-th WAIT cycle without a response.
                    timeout_s    = 1'b1;
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Output decode. Stall comes from state only. The write-port values are
    // computed here and registered below.
    always_comb begin
        stall_s      = (state_r == ST_WAIT);
        wr_next_s    = 1'b0;
        waddr_next_s = rf_waddr_r;
        wdata_next_s = rf_wdata_r;
        if (accept_alu_s) begin
            wr_next_s    = 1'b1;
            waddr_next_s = ex_rd;
            wdata_next_s = ex_alu_result;
        end else if (rsp_take_s && (cap_rd_r != {RA_W{1'b0}})) begin
            wr_next_s    = 1'b1;
            waddr_next_s = cap_rd_r;
            wdata_next_s = load_extract(cap_funct3_r, cap_off_r, mem_rsp_data);
        end else begin
            wr_next_s    = 1'b0;
        end
    end

    // Output registers. The address and data hold their last values
    // between writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_we_r        <= 1'b0;
            rf_waddr_r     <= {RA_W{1'b0}};
            rf_wdata_r     <= {XLEN{1'b0}};
            err_misalign_r <= 1'b0;
            err_timeout_r  <= 1'b0;
        end else begin
            rf_we_r        <= wr_next_s;
            rf_waddr_r     <= waddr_next_s;
            rf_wdata_r     <= wdata_next_s;
            err_misalign_r <= misalign_s;
            err_timeout_r  <= timeout_s;
        end
    end

    // Load capture registers and the saturating wait counter. The counter is
    // cleared when the stage enters WAIT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_rd_r     <= {RA_W{1'b0}};
            cap_funct3_r <= 3'd0;
            cap_off_r    <= 2'd0;
            cnt_r        <= {CNT_W{1'b0}};
        end else if (accept_load_s) begin
            cap_rd_r     <= ex_rd;
            cap_funct3_r <= ex_funct3;
            cap_off_r    <= ex_alu_result[1:0];
            cnt_r        <= {CNT_W{1'b0}};
        end else if (state_r == ST_WAIT) begin
            cnt_r        <= cnt_inc_s;
        end else begin
            cnt_r        <= cnt_r;
        end
    end

`ifdef MEM_WB_PERF_EN
    logic [31:0] perf_retired_r;
    logic [31:0] perf_load_stall_r;

    // Performance counters. Both wrap naturally at 2^32.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_retired_r    <= 32'd0;
            perf_load_stall_r <= 32'd0;
        end else begin
            perf_retired_r    <= perf_retired_r + {31'd0, rf_we_r};
            perf_load_stall_r <= perf_load_stall_r + {31'd0, stall_s};
        end
    end

    assign perf_retired    = perf_retired_r;
    assign perf_load_stall = perf_load_stall_r;
`endif

    assign stall_out    = stall_s;
    assign rf_we        = rf_we_r;
    assign rf_waddr     = rf_waddr_r;
    assign rf_wdata     = rf_wdata_r;
    assign fwd_valid    = rf_we_r;
    assign fwd_rd       = rf_waddr_r;
    assign fwd_data     = rf_wdata_r;
    assign err_misalign = err_misalign_r;
    assign err_timeout  = err_timeout_r;

endmodule

// File: tb/tb_mem_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_wb_stage
//
// Testbench for mem_wb_stage. A plan of operations (directed scenarios first,
// then random ones) is laid out on a cycle timeline before the clock starts.
// Each operation records its expected outputs at the cycles where they must
// appear. The plan is then played into the DUT, and every cycle's outputs are
// compared against the timeline. A directed asynchronous-reset scenario
// follows at the end.
// -----------------------------------------------------------------------------
module tb_mem_wb_stage;

    localparam int NCYC     = 3000;
    localparam int MAX_WAIT = 15;

    logic        clk;
    logic        reset;
    logic        ex_valid;
    logic [4:0]  ex_rd;
    logic        ex_wb_en;
    logic        ex_mem_read;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_alu_result;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        stall_out;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic        err_misalign;
    logic        err_timeout;
`ifdef MEM_WB_PERF_EN
    logic [31:0] perf_retired;
    logic [31:0] perf_load_stall;
`endif

    mem_wb_stage #(.XLEN(32), .RA_W(5), .MAX_WAIT(MAX_WAIT)) dut (
        .clk           (clk),
        .reset         (reset),
        .ex_valid      (ex_valid),
        .ex_rd         (ex_rd),
        .ex_wb_en      (ex_wb_en),
        .ex_mem_read   (ex_mem_read),
        .ex_funct3     (ex_funct3),
        .ex_alu_result (ex_alu_result),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .stall_out     (stall_out),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .fwd_valid     (fwd_valid),
        .fwd_rd        (fwd_rd),
        .fwd_data      (fwd_data),
        .err_misalign  (err_misalign),
`ifdef MEM_WB_PERF_EN
        .err_timeout   (err_timeout),
        .perf_retired  (perf_retired),
        .perf_load_stall (perf_load_stall)
`else
        .err_timeout   (err_timeout)
`endif
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus timeline
    logic        d_valid [NCYC];
    logic [4:0]  d_rd    [NCYC];
    logic        d_wb    [NCYC];
    logic        d_mr    [NCYC];
    logic [2:0]  d_f3    [NCYC];
    logic [31:0] d_alu   [NCYC];
    logic        d_rsp   [NCYC];
    logic [31:0] d_rdata [NCYC];
    // Expected-output timeline
    logic        e_we    [NCYC];
    logic [4:0]  e_waddr [NCYC];
    logic [31:0] e_wdata [NCYC];
    logic        e_stall [NCYC];
    logic        e_mis   [NCYC];
    logic        e_to    [NCYC];

    int n_checks;
    int n_errors;
    int cur_cycle;
    int t;

    // Counts one comparison and reports it when it does not match.
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cur_cycle, obs, exp);
        end
    endtask

    // Access size in bytes. Undefined funct3 values act like LW.
    function automatic int load_size(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
        int          sz;
        logic [31:0] mask;
        logic [31:0] v;
        sz = load_size(f3);
        if (sz == 4) return word;
        mask = (sz == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
        v = (word >> (8 * int'(addr % 4))) & mask;
        if ((f3 == 3'd0 || f3 == 3'd1) && ((v & ((mask >> 1) + 32'd1)) != 32'd0))
            v = v | ~mask;
        return v;
    endfunction

    // Garbage instruction, driven while the stage is stalled.
    task automatic plan_garbage(input int c);
        d_valid[c] = 1'b1;
        d_rd[c]    = 5'($urandom_range(0, 31));
        d_wb[c]    = 1'($urandom_range(0, 1));
        d_mr[c]    = 1'($urandom_range(0, 1));
        d_f3[c]    = 3'($urandom_range(0, 7));
        d_alu[c]   = $urandom();
    endtask

    task automatic plan_alu(input logic [4:0] rd, input logic wb, input logic [31:0] v);
        d_valid[t] = 1'b1;
        d_rd[t]    = rd;
        d_wb[t]    = wb;
        d_mr[t]    = 1'b0;
        d_f3[t]    = 3'($urandom_range(0, 7));
        d_alu[t]   = v;
        if (wb && rd != 5'd0) begin
            e_we[t+1]    = 1'b1;
            e_waddr[t+1] = rd;
            e_wdata[t+1] = v;
        end
        t = t + 1;
    endtask

    // lat is the response delay in cycles, 1..MAX_WAIT. A lat of 0 means no
    // response arrives, so the load times out.
    task automatic plan_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                             input int lat, input logic [31:0] word);
        int k;
        d_valid[t] = 1'b1;
        d_rd[t]    = rd;
        d_wb[t]    = 1'b1;
        d_mr[t]    = 1'b1;
        d_f3[t]    = f3;
        d_alu[t]   = addr;
        if ((addr % load_size(f3)) != 0) begin
            e_mis[t+1] = 1'b1;
            t = t + 1;
        end else begin
            k = (lat == 0) ? MAX_WAIT : lat;
            for (int i = 1; i <= k; i++) begin
                e_stall[t+i] = 1'b1;
                d_rsp[t+i]   = 1'b0;
                plan_garbage(t + i);
            end
            if (lat != 0) begin
                d_rsp[t+lat]   = 1'b1;
                d_rdata[t+lat] = word;
                if (rd != 5'd0) begin
                    e_we[t+lat+1]    = 1'b1;
                    e_waddr[t+lat+1] = rd;
                    e_wdata[t+lat+1] = ref_load(f3, addr, word);
                end
                t = t + lat + 1;
            end else begin
                e_to[t+MAX_WAIT+1]    = 1'b1;
                d_valid[t+MAX_WAIT+1] = 1'b0;
                d_rsp[t+MAX_WAIT+1]   = 1'b1;
                d_rdata[t+MAX_WAIT+1] = $urandom();
                t = t + MAX_WAIT + 2;
            end
        end
    endtask

    task automatic build_plan();
        int kind;
        int lat;
        for (int c = 0; c < NCYC; c++) begin
            d_valid[c] = 1'b0;
            d_rd[c]    = 5'($urandom_range(0, 31));
            d_wb[c]    = 1'($urandom_range(0, 1));
            d_mr[c]    = 1'($urandom_range(0, 1));
            d_f3[c]    = 3'($urandom_range(0, 7));
            d_alu[c]   = $urandom();
            d_rsp[c]   = ($urandom_range(0, 3) == 0);
            d_rdata[c] = $urandom();
            e_we[c]    = 1'b0;
            e_waddr[c] = 5'd0;
            e_wdata[c] = 32'd0;
            e_stall[c] = 1'b0;
            e_mis[c]   = 1'b0;
            e_to[c]    = 1'b0;
        end
        t = 1;
        // Directed scenarios
        plan_alu(5'd5, 1'b1, 32'h0000_1234);
        t = t + 1;
        plan_load(3'd0, 32'h0000_0103, 5'd9, 2, 32'h80AA_BBCC);
        plan_load(3'd4, 32'h0000_0103, 5'd10, 2, 32'h80AA_BBCC);
        plan_load(3'd2, 32'h0000_0102, 5'd11, 2, 32'h1111_2222);
        plan_load(3'd2, 32'h0000_0100, 5'd12, 0, 32'h0);
        plan_alu(5'd1, 1'b1, 32'hA000_0001);
        plan_alu(5'd2, 1'b1, 32'hA000_0002);
        plan_alu(5'd0, 1'b1, 32'hA000_0000);
        plan_alu(5'd3, 1'b1, 32'hA000_0003);
        plan_load(3'd5, 32'h0000_0202, 5'd0, 3, 32'hDEAD_BEEF);
        plan_load(3'd1, 32'h0000_0202, 5'd13, MAX_WAIT, 32'h8001_7FFF);
        plan_load(3'd7, 32'h0000_0301, 5'd14, 1, 32'h0);
        // Random scenarios
        while (t < NCYC - 40) begin
            kind = $urandom_range(0, 9);
            if (kind < 5) begin
                plan_alu(5'($urandom_range(0, 31)), 1'($urandom_range(0, 3) != 0), $urandom());
            end else begin
                lat = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 5);
                if ($urandom_range(0, 9) == 0) lat = MAX_WAIT;
                plan_load(3'($urandom_range(0, 7)), $urandom(), 5'($urandom_range(0, 31)), lat, $urandom());
            end
            t = t + $urandom_range(0, 2);
        end
    endtask

    initial begin
        logic [4:0]  m_waddr;
        logic [31:0] m_wdata;
        logic [31:0] m_ret;
        logic [31:0] m_stl;
        n_checks = 0;
        n_errors = 0;
        cur_cycle = -1;
        build_plan();

        reset = 1'b0;
        ex_valid = 1'b0; ex_rd = 5'd0; ex_wb_en = 1'b0; ex_mem_read = 1'b0;
        ex_funct3 = 3'd0; ex_alu_result = 32'd0;
        mem_rsp_valid = 1'b0; mem_rsp_data = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset_we", {31'd0, rf_we}, 32'd0);
        check_val("reset_waddr", {27'd0, rf_waddr}, 32'd0);
        check_val("reset_wdata", rf_wdata, 32'd0);
        check_val("reset_stall", {31'd0, stall_out}, 32'd0);
        check_val("reset_err", {30'd0, err_misalign, err_timeout}, 32'd0);
        reset = 1'b1;

        m_waddr = 5'd0;
        m_wdata = 32'd0;
        m_ret   = 32'd0;
        m_stl   = 32'd0;
        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            ex_valid      = d_valid[c];
            ex_rd         = d_rd[c];
            ex_wb_en      = d_wb[c];
            ex_mem_read   = d_mr[c];
            ex_funct3     = d_f3[c];
            ex_alu_result = d_alu[c];
            mem_rsp_valid = d_rsp[c];
            mem_rsp_data  = d_rdata[c];
            @(negedge clk);
            cur_cycle = c;
            if (e_we[c]) begin
                m_waddr = e_waddr[c];
                m_wdata = e_wdata[c];
            end
            check_val("rf_we", {31'd0, rf_we}, {31'd0, e_we[c]});
            check_val("rf_waddr", {27'd0, rf_waddr}, {27'd0, m_waddr});
            check_val("rf_wdata", rf_wdata, m_wdata);
            check_val("stall_out", {31'd0, stall_out}, {31'd0, e_stall[c]});
            check_val("err_misalign", {31'd0, err_misalign}, {31'd0, e_mis[c]});
            check_val("err_timeout", {31'd0, err_timeout}, {31'd0, e_to[c]});
            check_val("fwd_tap", {fwd_valid, 26'd0, fwd_rd}, {e_we[c], 26'd0, m_waddr});
            check_val("fwd_data", fwd_data, m_wdata);
`ifdef MEM_WB_PERF_EN
            check_val("perf_retired", perf_retired, m_ret);
            check_val("perf_load_stall", perf_load_stall, m_stl);
`endif
            m_ret = m_ret + {31'd0, e_we[c]};
            m_stl = m_stl + {31'd0, e_stall[c]};
        end

        // Reset asserted two cycles after a load is captured
        cur_cycle = NCYC;
        @(posedge clk);
        #1;
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_funct3 = 3'd2; ex_rd = 5'd7;
        ex_wb_en = 1'b1; ex_alu_result = 32'h0000_0200; mem_rsp_valid = 1'b0;
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        @(negedge clk);
        check_val("rst_wait_stall", {31'd0, stall_out}, 32'd1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_val("rst_mid_stall", {31'd0, stall_out}, 32'd0);
        check_val("rst_mid_out", {rf_we, fwd_valid, err_misalign, err_timeout, 23'd0, rf_waddr},
                  32'd0);
        check_val("rst_mid_wdata", rf_wdata, 32'd0);
`ifdef MEM_WB_PERF_EN
        check_val("rst_perf_stall", perf_load_stall, 32'd0);
        check_val("rst_perf_ret", perf_retired, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hCAFE_F00D;
        @(negedge clk);
        check_val("late_rsp_stall", {31'd0, stall_out}, 32'd0);
        @(posedge clk);
        #1;
        mem_rsp_valid = 1'b0;
        @(negedge clk);
        check_val("late_rsp_we", {31'd0, rf_we}, 32'd0);
        check_val("late_rsp_wdata", rf_wdata, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
